// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is radix-2 shift-add, divide is restoring shift-subtract; both
// run 32 iterations on magnitudes, then a fix-up cycle restores signs.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        startE,
    input  logic        multordivE,
    input  logic        signedE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        hlwriteW,
    input  logic        hlselW,
    input  logic [31:0] hlwdataW,
    input  logic        readhlD,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stallmd
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_div;
    logic        r_sa;
    logic        r_sb;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [33:0] w_div_trial;
    logic [63:0] w_div_next;
    logic [63:0] w_neg_acc;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    // Operand magnitudes; only signed ops take the absolute value.
    always_comb begin
        w_abs_a = (signedE && srcaE[31]) ? (~srcaE + 32'd1) : srcaE;
        w_abs_b = (signedE && srcbE[31]) ? (~srcbE + 32'd1) : srcbE;
    end

    // One iteration step: acc = {upper, lower}; lower starts as the magnitude of A.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[63:32]} + {1'b0, r_b};
        w_mul_next  = r_acc[0] ? {w_mul_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};
        w_div_trial = {1'b0, r_acc[63:31]} - {2'b00, r_b};
        // Borrow means the trial subtraction failed: restore by keeping the shifted value.
        w_div_next  = w_div_trial[33] ? {r_acc[62:0], 1'b0}
                                      : {w_div_trial[31:0], r_acc[30:0], 1'b1};
    end

    // Sign fix-up and divide-by-zero override applied in the FIX cycle.
    always_comb begin
        w_neg_acc = ~r_acc + 64'd1;
        w_fix_hi  = r_acc[63:32];
        w_fix_lo  = r_acc[31:0];
        if (!r_div) begin
            if (r_sa ^ r_sb) begin
                w_fix_hi = w_neg_acc[63:32];
                w_fix_lo = w_neg_acc[31:0];
            end
        end else if (r_b == 32'd0) begin
            // Reconstruct the raw dividend from its magnitude and sign.
            w_fix_hi = r_sa ? (~r_a + 32'd1) : r_a;
            w_fix_lo = 32'hFFFF_FFFF;
        end else begin
            w_fix_hi = r_sa ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
            w_fix_lo = (r_sa ^ r_sb) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= 6'd0;
            r_div   <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_acc   <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (hlwriteW) begin
                        if (hlselW) r_hi <= hlwdataW;
                        else        r_lo <= hlwdataW;
                    end
                    if (startE) begin
                        r_state <= StRun;
                        r_cnt   <= 6'd0;
                        r_div   <= multordivE;
                        r_sa    <= signedE & srcaE[31];
                        r_sb    <= signedE & srcbE[31];
                        r_a     <= w_abs_a;
                        r_b     <= w_abs_b;
                        r_acc   <= {32'd0, w_abs_a};
                    end
                end
                StRun: begin
                    r_acc <= r_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= StFix;
                end
                StFix: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_cnt   <= 6'd0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Status outputs; stall is combinational so the hazard unit sees it this cycle.
    always_comb begin
        busy    = (r_state != StIdle);
        done    = r_done;
        stallmd = busy & (startE | readhlD);
        hi      = r_hi;
        lo      = r_lo;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have a clock port: clk, input, 1 bit; single clock, all state updates on its rising edge.
REQ-002 SHALL have a reset port: reset, input, 1 bit; asynchronous, active-low (0 = reset).
REQ-003 SHALL have startE, input, 1 bit: launches a mult/div held in the Execute stage.
REQ-004 SHALL have multordivE, input, 1 bit: 0 = multiply, 1 = divide.
REQ-005 SHALL have signedE, input, 1 bit: 1 = signed (mult/div), 0 = unsigned (multu/divu).
REQ-006 SHALL have srcaE and srcbE, inputs, 32 bits each: operands; for divide, srcaE is the dividend.
REQ-007 SHALL have hlwriteW, input, 1 bit: direct HI/LO write (mthi/mtlo) from Writeback.
REQ-008 SHALL have hlselW, input, 1 bit (0 = LO, 1 = HI), and hlwdataW, input, 32 bits: direct write target and data.
REQ-009 SHALL have readhlD, input, 1 bit: a mfhi/mflo is in Decode.
REQ-010 SHALL have hi and lo, outputs, 32 bits: architectural HI/LO registers.
REQ-011 SHALL have busy, output, 1 bit: an operation is in progress.
REQ-012 SHALL have done, output, 1 bit: one-cycle pulse when new HI/LO is visible.
REQ-013 SHALL have stallmd, output, 1 bit: stall request to the hazard unit.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> FIX -> IDLE; busy = 1 in RUN and FIX.
REQ-015 In IDLE, startE=1 at an edge SHALL latch operands/mode and enter RUN with a 6-bit iteration counter = 0.
REQ-016 When signedE=1, operands SHALL be latched as absolute values, with their original signs recorded.
REQ-017 RUN SHALL perform exactly 32 iterations, one per cycle: radix-2 shift-add for multiply, restoring shift-subtract for divide, then enter FIX.
REQ-018 FIX SHALL apply the sign fix-up and write HI/LO at its closing edge, which is 33 edges after the start edge.
REQ-019 Multiply SHALL produce a 64-bit product with {hi,lo} = product; the signed product is negated iff the operand signs differ.
REQ-020 Divide SHALL produce lo = quotient and hi = remainder.
REQ-021 For a signed divide, the quotient sign SHALL be signA xor signB and the remainder sign SHALL equal signA.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-023 Divide by zero SHALL give lo = 0xFFFFFFFF and hi = srcaE as latched (raw), for both signed and unsigned, with the same latency.
REQ-024 done SHALL be 1 in exactly the one cycle after the FIX edge and 0 otherwise.
REQ-025 startE while busy SHALL be ignored; the operation in flight is unaffected.
REQ-026 stallmd SHALL be driven combinationally as busy & (startE | readhlD).
REQ-027 hlwriteW while busy SHALL be ignored.
REQ-028 hlwriteW while not busy SHALL write hlwdataW into the register chosen by hlselW.
REQ-029 hlwriteW and startE at the same IDLE edge SHALL both take effect; the later FIX write overwrites HI/LO.
REQ-030 hi and lo SHALL hold their values at all times except on a FIX write or an accepted hlwriteW.

Reset
REQ-031 reset=0 SHALL asynchronously force: state IDLE, counter 0, hi = lo = 0, busy = done = stallmd = 0, internal operands 0.
REQ-032 reset asserted mid-operation SHALL abort the operation; no partial result reaches hi/lo.
REQ-033 The first startE after reset deassertion SHALL be accepted normally.

Verification
REQ-034 Unsigned multiply 0xFFFFFFFF * 0xFFFFFFFF -> busy high for 33 cycles, then hi = 0xFFFFFFFE, lo = 0x00000001, done pulses once.
REQ-035 Signed multiply -3 * 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-036 Signed divide -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; signed 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
REQ-037 Unsigned 100 / 0 -> lo = 0xFFFFFFFF, hi = 0x00000064 after 33 cycles.
REQ-038 readhlD = 1 (or a second startE) during RUN -> stallmd = 1; the second start is ignored; hlwriteW hi = 0x1234 during RUN -> ignored.
REQ-039 reset pulsed low at cycle 10 of a divide -> hi = lo = 0 and busy = 0 immediately; a subsequent 6 * 7 multiply -> lo = 42.
